// File: rtl/data_mem_dp.sv
// Dual-port 32-bit data memory: port A is the core's byte-addressed load/store port,
// port B is a word port for the FFT engine. Both ports have 1-cycle registered reads.
module data_mem_dp #(
   parameter int ADDR_W    = 10,
   parameter bit INIT_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [2:0]        a_size,
   input  logic [ADDR_W+1:0] a_addr,
   input  logic [31:0]       a_wdata,
   output logic              a_ack,
   output logic [31:0]       a_rdata,
   output logic              a_err,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [31:0]       b_wdata,
   output logic              b_ack,
   output logic [31:0]       b_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [31:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] aIdx;
   logic [1:0]        aOff;
   logic              aSizeOk;
   logic              aAligned;
   logic              aErr;
   logic              aStore;
   logic [3:0]        aLaneWe;
   logic [31:0]       aWdataRep;
   logic [31:0]       aWord;
   logic [7:0]        aByte;
   logic [15:0]       aHalf;
   logic [31:0]       aRdata_d;
   logic              bWr;

   logic              aAck_q;
   logic              aErr_q;
   logic [31:0]       aRdata_q;
   logic              bAck_q;
   logic [31:0]       bRdata_q;

   generate
      if (INIT_ZERO) begin : g_initZero
         initial begin
            for (int i = 0; i < DEPTH; i++) begin
               mem_q[i] = 32'h0;
            end
         end
      end
   endgenerate

   assign aIdx = a_addr[ADDR_W+1:2];
   assign aOff = a_addr[1:0];

   always_comb begin
      aSizeOk   = 1'b0;
      aAligned  = 1'b1;
      aLaneWe   = 4'b0000;
      aWdataRep = a_wdata;
      aRdata_d  = 32'h0;

      if (a_we) begin
         aSizeOk = (a_size == 3'b000) || (a_size == 3'b001) || (a_size == 3'b010);
      end else begin
         aSizeOk = (a_size == 3'b000) || (a_size == 3'b001) || (a_size == 3'b010) ||
                   (a_size == 3'b100) || (a_size == 3'b101);
      end

      case (a_size[1:0])
         2'b01:   aAligned = ~aOff[0];
         2'b10:   aAligned = (aOff == 2'b00);
         default: aAligned = 1'b1;
      endcase

      aErr   = ~aSizeOk | ~aAligned;
      aStore = a_req & a_we & ~aErr & ~rst;

      // Store data is replicated across lanes so each lane picks up the right bits
      case (a_size[1:0])
         2'b00: begin
            aLaneWe   = 4'b0001 << aOff;
            aWdataRep = {4{a_wdata[7:0]}};
         end
         2'b01: begin
            aLaneWe   = aOff[1] ? 4'b1100 : 4'b0011;
            aWdataRep = {2{a_wdata[15:0]}};
         end
         default: begin
            aLaneWe   = 4'b1111;
            aWdataRep = a_wdata;
         end
      endcase
      if (!aStore) begin
         aLaneWe = 4'b0000;
      end

      aWord = mem_q[aIdx];
      aByte = aWord[{aOff, 3'b000} +: 8];
      aHalf = aOff[1] ? aWord[31:16] : aWord[15:0];

      if (!a_we && !aErr) begin
         case (a_size)
            3'b000:  aRdata_d = {{24{aByte[7]}}, aByte};
            3'b100:  aRdata_d = {24'h0, aByte};
            3'b001:  aRdata_d = {{16{aHalf[15]}}, aHalf};
            3'b101:  aRdata_d = {16'h0, aHalf};
            default: aRdata_d = aWord;
         endcase
      end

      bWr = b_req & b_we & ~rst;
   end

   // On a same-word collision port A owns its enabled lanes; port B fills the rest
   always_ff @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         if (bWr && !(aLaneWe[l] && (aIdx == b_addr))) begin
            mem_q[b_addr][8*l +: 8] <= b_wdata[8*l +: 8];
         end
         if (aLaneWe[l]) begin
            mem_q[aIdx][8*l +: 8] <= aWdataRep[8*l +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aAck_q   <= 1'b0;
         aErr_q   <= 1'b0;
         aRdata_q <= 32'h0;
         bAck_q   <= 1'b0;
         bRdata_q <= 32'h0;
      end else begin
         aAck_q   <= a_req;
         aErr_q   <= a_req & aErr;
         aRdata_q <= a_req ? aRdata_d : 32'h0;
         bAck_q   <= b_req;
         bRdata_q <= (b_req && !b_we) ? mem_q[b_addr] : 32'h0;
      end
   end

   // Reset also masks an ack already registered from the previous cycle
   assign a_ack   = aAck_q & ~rst;
   assign a_err   = aErr_q & ~rst;
   assign a_rdata = rst ? 32'h0 : aRdata_q;
   assign b_ack   = bAck_q & ~rst;
   assign b_rdata = rst ? 32'h0 : bRdata_q;

endmodule

// File: tb/tb_data_mem_dp.sv
// Randomised and directed bench for data_mem_dp against a word-array reference model
// that tracks expected outputs one cycle ahead.
module tb_data_mem_dp;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req;
   logic        a_we;
   logic [2:0]  a_size;
   logic [11:0] a_addr;
   logic [31:0] a_wdata;
   logic        a_ack;
   logic [31:0] a_rdata;
   logic        a_err;
   logic        b_req;
   logic        b_we;
   logic [9:0]  b_addr;
   logic [31:0] b_wdata;
   logic        b_ack;
   logic [31:0] b_rdata;

   int errors = 0;
   int checks = 0;

   logic [31:0] model [1024];
   logic        expAAck, expAErr, expBAck;
   logic [31:0] expAData, expBData;

   always #5 clk = ~clk;

   data_mem_dp #(.ADDR_W(10), .INIT_ZERO(1'b1)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, check what the previous cycle produced, then advance the model
   task automatic applyStimulus(input logic r, input logic aq, input logic aw, input logic [2:0] as,
                                input logic [11:0] aa, input logic [31:0] ad,
                                input logic bq, input logic bw, input logic [9:0] ba,
                                input logic [31:0] bd);
      int          nBytes;
      int          sh;
      bit          sizeOk;
      logic [31:0] mask;
      logic [31:0] v;
      logic        nAAck, nAErr, nBAck;
      logic [31:0] nAData, nBData;

      rst = r; a_req = aq; a_we = aw; a_size = as; a_addr = aa; a_wdata = ad;
      b_req = bq; b_we = bw; b_addr = ba; b_wdata = bd;
      #1;
      checkOutput("a_ack",   {31'b0, a_ack}, r ? 32'h0 : {31'b0, expAAck});
      checkOutput("a_err",   {31'b0, a_err}, r ? 32'h0 : {31'b0, expAErr});
      checkOutput("a_rdata", a_rdata,        r ? 32'h0 : expAData);
      checkOutput("b_ack",   {31'b0, b_ack}, r ? 32'h0 : {31'b0, expBAck});
      checkOutput("b_rdata", b_rdata,        r ? 32'h0 : expBData);

      nAAck = 1'b0; nAErr = 1'b0; nBAck = 1'b0; nAData = 32'h0; nBData = 32'h0;
      mask = 32'h0; sh = 0;
      if (!r) begin
         if (aq) begin
            nAAck  = 1'b1;
            nBytes = 1 << as[1:0];
            sizeOk = aw ? (as <= 3'd2) : (as inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            if (!sizeOk || (int'(aa) % nBytes) != 0) begin
               nAErr = 1'b1;
            end else begin
               sh   = 8 * (int'(aa) % 4);
               mask = (nBytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nBytes)) - 32'd1);
               if (!aw) begin
                  v = (model[aa / 4] >> sh) & mask;
                  if (!as[2] && nBytes < 4 && ((v >> (8 * nBytes - 1)) & 32'd1) != 0) begin
                     v = v | ~mask;
                  end
                  nAData = v;
               end
            end
         end
         if (bq) begin
            nBAck = 1'b1;
            if (!bw) nBData = model[ba];
         end
         if (bq && bw) model[ba] = bd;
         if (aq && aw && !nAErr) begin
            model[aa / 4] = (model[aa / 4] & ~(mask << sh)) | ((ad & mask) << sh);
         end
      end
      expAAck = nAAck; expAErr = nAErr; expAData = nAData;
      expBAck = nBAck; expBData = nBData;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 3'b000, 12'h0, 32'h0, 0, 0, 10'h0, 32'h0);
   endtask

   task automatic portA(input logic aw, input logic [2:0] as, input logic [11:0] aa,
                        input logic [31:0] ad);
      applyStimulus(0, 1, aw, as, aa, ad, 0, 0, 10'h0, 32'h0);
   endtask

   task automatic portB(input logic bw, input logic [9:0] ba, input logic [31:0] bd);
      applyStimulus(0, 0, 0, 3'b000, 12'h0, 32'h0, 1, bw, ba, bd);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) model[i] = 32'h0;
      expAAck = 0; expAErr = 0; expBAck = 0; expAData = 0; expBData = 0;

      // Requests under reset must neither ack nor write
      applyStimulus(1, 1, 1, 3'b010, 12'h000, 32'hDEAD_BEEF, 1, 1, 10'd1, 32'hCAFE_F00D);
      applyStimulus(1, 1, 1, 3'b010, 12'h000, 32'hDEAD_BEEF, 1, 1, 10'd1, 32'hCAFE_F00D);
      checkOutput("rst_a_ack", {31'b0, a_ack}, 32'h0);
      foreach (model[i]) if (i < 3) begin end
      portA(0, 3'b010, 12'h000, 32'h0);
      checkOutput("lw0_ack", {31'b0, a_ack}, 32'h1);
      checkOutput("lw0_data", a_rdata, 32'h0);
      portA(0, 3'b010, 12'h004, 32'h0);
      checkOutput("lw4_data", a_rdata, 32'h0);
      portB(0, 10'd1, 32'h0);
      checkOutput("b1_after_rst", b_rdata, 32'h0);

      // Store just before reset stays committed; the following ack is masked
      portA(1, 3'b010, 12'h008, 32'h0000_0055);
      applyStimulus(1, 1, 0, 3'b010, 12'h008, 32'h0, 0, 0, 10'h0, 32'h0);
      checkOutput("rst_mid_ack", {31'b0, a_ack}, 32'h0);
      portA(0, 3'b010, 12'h008, 32'h0);
      checkOutput("lw8_kept", a_rdata, 32'h0000_0055);

      portA(1, 3'b010, 12'h010, 32'h8000_00F0);
      portA(0, 3'b000, 12'h010, 32'h0);
      checkOutput("lb_10", a_rdata, 32'hFFFF_FFF0);
      portA(0, 3'b100, 12'h010, 32'h0);
      checkOutput("lbu_10", a_rdata, 32'h0000_00F0);
      portA(0, 3'b001, 12'h012, 32'h0);
      checkOutput("lh_12", a_rdata, 32'hFFFF_8000);
      portA(0, 3'b101, 12'h012, 32'h0);
      checkOutput("lhu_12", a_rdata, 32'h0000_8000);

      portA(1, 3'b000, 12'h021, 32'h0000_00AB);
      portB(0, 10'd8, 32'h0);
      checkOutput("b_word8", b_rdata, 32'h0000_AB00);
      portB(1, 10'd9, 32'h1234_5678);
      portA(0, 3'b010, 12'h024, 32'h0);
      checkOutput("lw_24", a_rdata, 32'h1234_5678);

      portA(0, 3'b001, 12'h013, 32'h0);
      checkOutput("lh13_err", {31'b0, a_err}, 32'h1);
      checkOutput("lh13_data", a_rdata, 32'h0);
      portA(1, 3'b010, 12'h022, 32'hFFFF_FFFF);
      checkOutput("sw22_err", {31'b0, a_err}, 32'h1);
      portA(0, 3'b011, 12'h020, 32'h0);
      checkOutput("sz011_ack", {31'b0, a_ack}, 32'h1);
      checkOutput("sz011_err", {31'b0, a_err}, 32'h1);
      portB(0, 10'd8, 32'h0);
      checkOutput("b_word8_kept", b_rdata, 32'h0000_AB00);

      // Same-word collision, then a read racing a write to the same word
      applyStimulus(0, 1, 1, 3'b001, 12'h040, 32'h0000_BEEF, 1, 1, 10'd16, 32'h1111_1111);
      portB(0, 10'd16, 32'h0);
      checkOutput("collide16", b_rdata, 32'h1111_BEEF);
      applyStimulus(0, 1, 1, 3'b010, 12'h040, 32'h2222_2222, 1, 0, 10'd16, 32'h0);
      checkOutput("readfirst16", b_rdata, 32'h1111_BEEF);
      portA(0, 3'b010, 12'h040, 32'h0);
      checkOutput("lw_40_new", a_rdata, 32'h2222_2222);

      for (int c = 0; c < 10000; c++) begin
         applyStimulus(($urandom % 64) == 0, 1'($urandom), 1'($urandom), 3'($urandom),
                       12'($urandom_range(0, 79)), $urandom,
                       1'($urandom), 1'($urandom), 10'($urandom_range(0, 19)), $urandom);
      end
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
